// File: rtl/text_console_pkg.sv
// -----------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the character-cell text console: default screen
// geometry, the ASCII codes the console interprets, the FSM state type and a
// helper that classifies printable bytes.
// -----------------------------------------------------------------------------
package text_console_pkg;

  // Default geometry: 1280x800 pixels with an 8x16 font.
  localparam int DEFAULT_COLS = 160;
  localparam int DEFAULT_ROWS = 50;

  // Interpreted ASCII codes.
  localparam logic [7:0] CH_SPACE    = 8'h20;
  localparam logic [7:0] CH_BS       = 8'h08;
  localparam logic [7:0] CH_LF       = 8'h0A;
  localparam logic [7:0] CH_FF       = 8'h0C;
  localparam logic [7:0] CH_CR       = 8'h0D;
  localparam logic [7:0] CH_PRINT_LO = 8'h20;
  localparam logic [7:0] CH_PRINT_HI = 8'h7E;

  typedef enum logic {
    CLEAR,
    RUN
  } console_state_t;

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_ram.sv
// -----------------------------------------------------------------------------
// text_ram
// Simple dual-port character store, 2^ADDR_W x 8 bits, written for block-RAM
// inference. One synchronous write port, one registered read port. A read and
// a write to the same address on the same edge return the old contents.
//
// Ports:
//   clk      in   clock
//   we_i     in   write enable
//   waddr_i  in   write address
//   wdata_i  in   write data
//   raddr_i  in   read address, sampled on the rising edge
//   rdata_o  out  read data, valid one cycle after raddr_i is sampled
// -----------------------------------------------------------------------------
module text_ram #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rdata_q;

  // NOTE: the array and its output register get no reset; a reset port would
  // stop the synthesiser from mapping them onto a block RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    // NOTE: non-blocking assignments make this read see the array value from
    // before the write on the same edge, which is the read-before-write rule.
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/text_console.sv
// -----------------------------------------------------------------------------
// text_console
// Character-cell terminal buffer feeding the 8x16 font renderer. Bytes arrive
// over a valid/ready handshake: printable codes are stored at the cursor and
// advance it, LF/CR/BS move the cursor, FF clears the screen. The renderer
// reads any cell with one cycle of latency, independently of the FSM.
//
// Optional feature: define TEXT_CONSOLE_CURSOR_EN to add a blinking cursor
// overlay on rd_cursor; without it rd_cursor is tied low.
//
// Ports:
//   clk         in   pixel clock
//   reset_n     in   synchronous active-low reset; restarts the screen clear
//   in_valid    in   in_char is valid
//   in_ready    out  a byte can be accepted this cycle (high only in RUN)
//   in_char     in   byte to store or interpret
//   rd_col      in   renderer column request
//   rd_row      in   renderer row request
//   rd_char     out  character at the requested cell, one cycle later
//   rd_cursor   out  cursor overlay flag aligned with rd_char
//   cursor_col  out  current cursor column
//   cursor_row  out  current cursor row
//   busy        out  high while the screen is being cleared
// -----------------------------------------------------------------------------
module text_console
  import text_console_pkg::*;
#(
  parameter int COLS    = DEFAULT_COLS,
  parameter int ROWS    = DEFAULT_ROWS,
  parameter int ADDR_W  = 13,
  parameter int BLINK_W = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_char,
  input  logic [7:0] rd_col,
  input  logic [5:0] rd_row,
  output logic [7:0] rd_char,
  output logic       rd_cursor,
  output logic [7:0] cursor_col,
  output logic [5:0] cursor_row,
  output logic       busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);
  localparam logic [7:0]        LAST_COL  = 8'(COLS - 1);
  localparam logic [5:0]        LAST_ROW  = 6'(ROWS - 1);

  console_state_t    state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [7:0]        cur_col_q;
  logic [5:0]        cur_row_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              rd_blank_q;

  logic              accept;
  logic [5:0]        next_row;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;

  // in_ready_q is high exactly when the FSM is in RUN.
  assign accept   = in_valid && in_ready_q;
  assign next_row = (cur_row_q == LAST_ROW) ? 6'd0 : cur_row_q + 6'd1;

  // Cell addresses are formed at 32 bits and only then cut to ADDR_W, so
  // out-of-range requests cannot alias through an early truncation.
  assign cur_addr    = ADDR_W'(32'(cur_row_q) * 32'(COLS) + 32'(cur_col_q));
  assign rd_addr     = ADDR_W'(32'(rd_row) * 32'(COLS) + 32'(rd_col));
  assign rd_in_range = (32'(rd_col) < 32'(COLS)) && (32'(rd_row) < 32'(ROWS));

  // Write port: the clear sweep owns it in CLEAR, accepted printables in RUN.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    ram_we    = 1'b0;
    ram_waddr = cur_addr;
    ram_wdata = in_char;
    if (reset_n) begin
      if (state_q == CLEAR) begin
        ram_we    = 1'b1;
        ram_waddr = clr_addr_q;
        ram_wdata = CH_SPACE;
      end else if (accept && is_printable(in_char)) begin
        ram_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      cur_col_q  <= 8'd0;
      cur_row_q  <= 6'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_addr_q <= clr_addr_q + ADDR_W'(1);
          if (clr_addr_q == LAST_ADDR) begin
            state_q    <= RUN;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (is_printable(in_char)) begin
              if (cur_col_q == LAST_COL) begin
                cur_col_q <= 8'd0;
                cur_row_q <= next_row;
              end else begin
                cur_col_q <= cur_col_q + 8'd1;
              end
            end else begin
              case (in_char)
                CH_LF: begin
                  cur_col_q <= 8'd0;
                  cur_row_q <= next_row;
                end
                CH_CR: cur_col_q <= 8'd0;
                CH_BS: begin
                  if (cur_col_q != 8'd0) cur_col_q <= cur_col_q - 8'd1;
                end
                CH_FF: begin
                  cur_col_q  <= 8'd0;
                  cur_row_q  <= 6'd0;
                  clr_addr_q <= '0;
                  state_q    <= CLEAR;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                end
                default: ;  // other control bytes are consumed silently
              endcase
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Out-of-range requests still read the RAM; the flag substitutes a space on
  // the aligned output. Its reset value also gives rd_char = space in reset.
  always_ff @(posedge clk) begin
    if (!reset_n) rd_blank_q <= 1'b1;
    else          rd_blank_q <= !rd_in_range;
  end

  text_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign rd_char    = rd_blank_q ? CH_SPACE : ram_rdata;
  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign cursor_col = cur_col_q;
  assign cursor_row = cur_row_q;

`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [BLINK_W-1:0] blink_q;
  logic               rd_cursor_q;

  // The overlay is registered alongside the RAM read so it lines up with
  // rd_char; the counter MSB sets the blink phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      blink_q     <= '0;
      rd_cursor_q <= 1'b0;
    end else begin
      blink_q     <= blink_q + BLINK_W'(1);
      rd_cursor_q <= (rd_row == cur_row_q) && (rd_col == cur_col_q) &&
                     blink_q[BLINK_W-1] && (state_q == RUN);
    end
  end

  assign rd_cursor = rd_cursor_q;
`else
  assign rd_cursor = 1'b0;
`endif

endmodule

// File: tb/tb_text_console.sv
module tb_text_console;

  typedef struct {
    logic [7:0] exp;
    string      tag;
  } rd_exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic [7:0] rd_col;
  logic [5:0] rd_row;
  logic [7:0] rd_char;
  logic       rd_cursor;
  logic [7:0] cursor_col;
  logic [5:0] cursor_row;
  logic       busy;

  int      n_checks = 0;
  int      n_fail   = 0;
  rd_exp_t sb[$];
  logic    rd_issue = 1'b0;

  always #5 clk = ~clk;

  text_console dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_char    (in_char),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_char    (rd_char),
    .rd_cursor  (rd_cursor),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a read issued before edge N is checked after edge N.
  initial begin
    rd_exp_t e;
    forever begin
      @(posedge clk);
      if (rd_issue) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard empty: got rd_char 0x%0h with no expectation", rd_char);
        end else begin
          e = sb.pop_front();
          check(e.tag, {24'b0, rd_char}, {24'b0, e.exp});
        end
      end
    end
  end

  // All tasks are entered 1 time unit after a rising edge and return likewise.
  task automatic rd(input int r, input int c, input logic [7:0] e, input string tag);
    rd_exp_t x;
    rd_row   = 6'(r);
    rd_col   = 8'(c);
    rd_issue = 1'b1;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1 rd_issue = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_char  = b;
    @(negedge clk);
    while (!in_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send timeout: byte 0x%0h never accepted", b);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_n(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) send(b);
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    check({tag, " cursor_row"}, {26'b0, cursor_row}, 32'(r));
    check({tag, " cursor_col"}, {24'b0, cursor_col}, 32'(c));
  endtask

  task automatic count_low(output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 9000) begin
      @(posedge clk);
      #1 cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    rd_row   = 6'd0;
    rd_col   = 8'd0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    check("reset busy", {31'b0, busy}, 32'd1);
    chk_cursor("reset", 0, 0);
    check("reset rd_char", {24'b0, rd_char}, 32'h20);
    check("reset rd_cursor", {31'b0, rd_cursor}, 32'd0);

    // Initial clear length
    @(posedge clk);
    #1 reset_n = 1'b1;
    count_low(cnt);
    check("initial clear cycles", 32'(cnt), 32'd8000);
    check("busy after clear", {31'b0, busy}, 32'd0);
    rd(0, 0, 8'h20, "cleared (0,0)");
    rd(49, 159, 8'h20, "cleared (49,159)");
    rd(10, 10, 8'h20, "cleared (10,10)");

    // HOLA
    send(8'h48); send(8'h4F); send(8'h4C); send(8'h41);
    rd(0, 0, 8'h48, "HOLA (0,0)");
    rd(0, 1, 8'h4F, "HOLA (0,1)");
    rd(0, 2, 8'h4C, "HOLA (0,2)");
    rd(0, 3, 8'h41, "HOLA (0,3)");
    chk_cursor("HOLA", 0, 4);

    // Same-cycle write and read of (0,5): old data first, new data next
    send(8'h20);
    chk_cursor("before RBW", 0, 5);
    in_valid = 1'b1;
    in_char  = 8'h51;
    rd_row   = 6'd0;
    rd_col   = 8'd5;
    rd_issue = 1'b1;
    sb.push_back('{8'h20, "RBW old (0,5)"});
    @(posedge clk);
    #1 in_valid = 1'b0;
    rd_issue = 1'b0;
    rd(0, 5, 8'h51, "RBW new (0,5)");
    chk_cursor("after RBW", 0, 6);

    // Wrap at the bottom-right corner
    send_n(8'h0A, 49);
    send_n(8'h20, 158);
    chk_cursor("pre-wrap", 49, 158);
    send(8'h41); send(8'h42);
    rd(49, 158, 8'h41, "wrap (49,158)");
    rd(49, 159, 8'h42, "wrap (49,159)");
    chk_cursor("post-wrap", 0, 0);
    send_n(8'h0A, 49);
    chk_cursor("LF to row 49", 49, 0);
    send(8'h0A);
    chk_cursor("LF wrap", 0, 0);

    // Control codes
    send(8'h58); send(8'h0D); send(8'h08);
    chk_cursor("X CR BS", 0, 0);
    rd(0, 0, 8'h58, "X at (0,0)");
    send(8'h07);
    chk_cursor("BEL", 0, 0);
    check("BEL in_ready", {31'b0, in_ready}, 32'd1);
    send(8'h0A); send(8'h61); send(8'h62);
    chk_cursor("ab", 1, 2);
    send(8'h08);
    chk_cursor("BS at col 2", 1, 1);
    rd(1, 1, 8'h62, "BS no write (1,1)");

    // Read edge cases: (0,160) would alias to (1,0)='a' without the range check
    rd(0, 160, 8'h20, "oob col 160");
    rd(0, 200, 8'h20, "oob col 200");
    rd(55, 0, 8'h20, "oob row 55");
`ifndef TEXT_CONSOLE_CURSOR_EN
    rd(1, 1, 8'h62, "cursor cell (1,1)");
    @(negedge clk);
    check("rd_cursor tied low", {31'b0, rd_cursor}, 32'd0);
    @(posedge clk);
    #1;
`endif

    // FF mid-stream
    send(8'h0A); send(8'h0A);
    send_n(8'h20, 3);
    send(8'h5A);
    rd(3, 3, 8'h5A, "Z at (3,3)");
    send(8'h0C);
    check("FF in_ready low", {31'b0, in_ready}, 32'd0);
    check("FF busy", {31'b0, busy}, 32'd1);
    chk_cursor("FF", 0, 0);
    count_low(cnt);
    check("FF clear cycles", 32'(cnt), 32'd8000);
    rd(3, 3, 8'h20, "cleared (3,3)");
    rd(0, 0, 8'h20, "cleared (0,0) after FF");

    // Reset during clear restarts the sweep from address 0
    send(8'h61); send(8'h62);
    send(8'h0C);
    repeat (100) @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid-clear reset in_ready", {31'b0, in_ready}, 32'd0);
    check("mid-clear reset busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b1;
    count_low(cnt);
    check("restarted clear cycles", 32'(cnt), 32'd8000);
    chk_cursor("after restart", 0, 0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
